// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Holds the FSM states, opcode map, ALU operation codes and trap causes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXECUTE    = 3'd2,
        ST_MEM        = 3'd3,
        ST_WRITE_BACK = 3'd4,
        ST_TRAP       = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_MEM,
        CL_BZ,
        CL_BGZ,
        CL_BLZ,
        CL_JR,
        CL_J,
        CL_CLL
    } op_class_t;

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_ORI  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_LDW  = 4'd8;
    localparam logic [3:0] OP_SDW  = 4'd9;
    localparam logic [3:0] OP_BZ   = 4'd10;
    localparam logic [3:0] OP_BGZ  = 4'd11;
    localparam logic [3:0] OP_BLZ  = 4'd12;
    localparam logic [3:0] OP_JR   = 4'd13;
    localparam logic [3:0] OP_J    = 4'd14;
    localparam logic [3:0] OP_CLL  = 4'd15;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_CMP = 2'b11;

    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_ODD_REG     = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b10;
    localparam logic [1:0] CAUSE_BUS_TIMEOUT = 2'b11;

endpackage

// File: rtl/mc_ctrl_if.sv
// Memory handshake bundle between the control FSM (master) and the data memory port (slave).
interface mc_ctrl_if #(
    parameter int DW_BEATS = 2
);
    localparam int BEAT_W = $clog2(DW_BEATS);

    logic              mem_read;
    logic              mem_write;
    logic              mem_ready;
    logic              stall;
    logic [BEAT_W-1:0] beat_idx;
    logic              second_cycle;

    modport master (
        output mem_read, mem_write, stall, beat_idx, second_cycle,
        input  mem_ready
    );

    modport slave (
        input  mem_read, mem_write, stall, beat_idx, second_cycle,
        output mem_ready
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decoder: classifies the latched opcode and supplies the EXECUTE ALU controls.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class,
    output logic [1:0]          alu_op,
    output logic                alu_src_b,
    output logic                is_mem,
    output logic                is_load,
    output logic                is_dw,
    output logic                illegal
);

    // Only the low nibble selects an operation; any higher bit set makes the opcode illegal.
    assign illegal = (opcode >> 4) != '0;

    always_comb begin
        op_class  = CL_ALU;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        is_mem    = 1'b0;
        is_load   = 1'b0;
        is_dw     = 1'b0;
        case (opcode[3:0])
            OP_OR:   alu_op = ALU_OR;
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_CMP:  alu_op = ALU_CMP;
            OP_ORI: begin
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
            end
            OP_ADDI: alu_src_b = 1'b1;
            OP_LW, OP_SW, OP_LDW, OP_SDW: begin
                op_class  = CL_MEM;
                alu_src_b = 1'b1;
                is_mem    = 1'b1;
                is_load   = (opcode[3:0] == OP_LW) || (opcode[3:0] == OP_LDW);
                is_dw     = (opcode[3:0] == OP_LDW) || (opcode[3:0] == OP_SDW);
            end
            OP_BZ: begin
                op_class = CL_BZ;
                alu_op   = ALU_SUB;
            end
            OP_BGZ: begin
                op_class = CL_BGZ;
                alu_op   = ALU_SUB;
            end
            OP_BLZ: begin
                op_class = CL_BLZ;
                alu_op   = ALU_SUB;
            end
            OP_JR:   op_class = CL_JR;
            OP_J:    op_class = CL_J;
            OP_CLL:  op_class = CL_CLL;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control FSM for the simple RISC core, with a timed memory handshake,
// multi-beat double-word transfers and a TRAP state for faults.
module mc_ctrl_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int DW_BEATS    = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                positive,
    input  logic                negative,
    input  logic                exception,
    mc_ctrl_if.master           mem,
    output logic                pc_write,
    output logic                reg_read,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                reg_write_addr_sel,
    output logic                branch,
    output logic                jump,
    output logic                jr,
    output logic [1:0]          alu_op,
    output logic                alu_src_b,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state
);

    localparam int BEAT_W = $clog2(DW_BEATS);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DW_BEATS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            cur_state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    op_class_t         op_class;
    logic [1:0]        dec_alu_op;
    logic              dec_alu_src_b;
    logic              is_mem;
    logic              is_load;
    logic              is_dw;
    logic              illegal;
    logic              last_beat;

    mc_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode    (opcode),
        .op_class  (op_class),
        .alu_op    (dec_alu_op),
        .alu_src_b (dec_alu_src_b),
        .is_mem    (is_mem),
        .is_load   (is_load),
        .is_dw     (is_dw),
        .illegal   (illegal)
    );

    assign last_beat = !is_dw || (beat_cnt == LAST_BEAT);
    assign state     = cur_state;

    // The timeout check sits below mem_ready so a handshake on the final allowed cycle still completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= ST_FETCH;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            trap_cause <= CAUSE_NONE;
        end else begin
            case (cur_state)
                ST_FETCH: cur_state <= ST_DECODE;
                ST_DECODE: begin
                    if (illegal) begin
                        cur_state  <= ST_TRAP;
                        trap_cause <= CAUSE_ILLEGAL;
                    end else if (exception && is_dw) begin
                        cur_state  <= ST_TRAP;
                        trap_cause <= CAUSE_ODD_REG;
                    end else begin
                        cur_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (is_mem) begin
                        cur_state <= ST_MEM;
                    end else if (op_class == CL_ALU || op_class == CL_CLL) begin
                        cur_state <= ST_WRITE_BACK;
                    end else begin
                        cur_state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (mem.mem_ready) begin
                        wait_cnt <= '0;
                        if (is_load) begin
                            cur_state <= ST_WRITE_BACK;
                        end else if (last_beat) begin
                            cur_state <= ST_FETCH;
                            beat_cnt  <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur_state  <= ST_TRAP;
                        trap_cause <= CAUSE_BUS_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WRITE_BACK: begin
                    if (is_load && !last_beat) begin
                        cur_state <= ST_MEM;
                        beat_cnt  <= beat_cnt + 1'b1;
                    end else begin
                        cur_state <= ST_FETCH;
                        beat_cnt  <= '0;
                    end
                end
                default: begin
                    cur_state <= ST_FETCH;
                    beat_cnt  <= '0;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

    // Reset masks every enable at once so an in-flight memory access drops in the same cycle.
    always_comb begin
        pc_write           = 1'b0;
        reg_read           = 1'b0;
        reg_write          = 1'b0;
        mem_to_reg         = 1'b0;
        reg_write_addr_sel = 1'b0;
        branch             = 1'b0;
        jump               = 1'b0;
        jr                 = 1'b0;
        alu_op             = ALU_ADD;
        alu_src_b          = 1'b0;
        trap               = 1'b0;
        mem.mem_read       = 1'b0;
        mem.mem_write      = 1'b0;
        mem.stall          = 1'b0;
        mem.beat_idx       = '0;
        mem.second_cycle   = 1'b0;
        if (!reset) begin
            mem.beat_idx     = beat_cnt;
            mem.second_cycle = beat_cnt != '0;
            case (cur_state)
                ST_FETCH:  pc_write = 1'b1;
                ST_DECODE: reg_read = 1'b1;
                ST_EXECUTE: begin
                    alu_op    = dec_alu_op;
                    alu_src_b = dec_alu_src_b;
                    case (op_class)
                        CL_BZ: begin
                            branch   = zero;
                            pc_write = zero;
                        end
                        CL_BGZ: begin
                            branch   = positive;
                            pc_write = positive;
                        end
                        CL_BLZ: begin
                            branch   = negative;
                            pc_write = negative;
                        end
                        CL_JR: begin
                            pc_write = 1'b1;
                            jr       = 1'b1;
                        end
                        CL_J, CL_CLL: begin
                            pc_write = 1'b1;
                            jump     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem.mem_read  = is_load;
                    mem.mem_write = !is_load;
                    mem.stall     = !mem.mem_ready;
                end
                ST_WRITE_BACK: begin
                    reg_write          = 1'b1;
                    mem_to_reg         = is_load;
                    reg_write_addr_sel = (op_class == CL_CLL);
                end
                ST_TRAP: begin
                    trap     = 1'b1;
                    pc_write = 1'b1;
                    jump     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: walks each instruction class cycle by cycle against hand-derived
// state and enable sequences, including memory waits, timeout, double-word beats and traps.
module tb_mc_ctrl_unit;
    import mc_ctrl_pkg::*;

    localparam logic [11:0] C_PCW   = 12'h800;
    localparam logic [11:0] C_RR    = 12'h400;
    localparam logic [11:0] C_RW    = 12'h200;
    localparam logic [11:0] C_MR    = 12'h100;
    localparam logic [11:0] C_MW    = 12'h080;
    localparam logic [11:0] C_MTR   = 12'h040;
    localparam logic [11:0] C_RWS   = 12'h020;
    localparam logic [11:0] C_BR    = 12'h010;
    localparam logic [11:0] C_JMP   = 12'h008;
    localparam logic [11:0] C_JR    = 12'h004;
    localparam logic [11:0] C_TRAP  = 12'h002;
    localparam logic [11:0] C_STALL = 12'h001;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero, positive, negative, exception;
    logic       pc_write, reg_read, reg_write, mem_to_reg, reg_write_addr_sel;
    logic       branch, jump, jr, alu_src_b, trap;
    logic [1:0] alu_op, trap_cause;
    logic [2:0] state;
    logic [11:0] ctl;
    int n_cmp = 0;
    int n_err = 0;

    mc_ctrl_if #(.DW_BEATS(4)) mem_bus ();

    mc_ctrl_unit #(.OPCODE_W(6), .DW_BEATS(4), .MEM_TIMEOUT(15)) dut (
        .clk                (clk),
        .reset              (reset),
        .opcode             (opcode),
        .zero               (zero),
        .positive           (positive),
        .negative           (negative),
        .exception          (exception),
        .mem                (mem_bus),
        .pc_write           (pc_write),
        .reg_read           (reg_read),
        .reg_write          (reg_write),
        .mem_to_reg         (mem_to_reg),
        .reg_write_addr_sel (reg_write_addr_sel),
        .branch             (branch),
        .jump               (jump),
        .jr                 (jr),
        .alu_op             (alu_op),
        .alu_src_b          (alu_src_b),
        .trap               (trap),
        .trap_cause         (trap_cause),
        .state              (state)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_write, reg_read, reg_write, mem_bus.mem_read, mem_bus.mem_write, mem_to_reg,
                  reg_write_addr_sel, branch, jump, jr, trap, mem_bus.stall};

    task automatic test_reset();
        reset = 1'b1; opcode = '0; zero = 1'b0; positive = 1'b0; negative = 1'b0;
        exception = 1'b0; mem_bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (ctl !== 12'h000) begin n_err++; $display("[TB] FAIL reset_ctl got %h want 000", ctl); end
        n_cmp++; if ({alu_op, alu_src_b, mem_bus.beat_idx, mem_bus.second_cycle} !== 6'd0) begin
            n_err++; $display("[TB] FAIL reset_misc got %b want 000000", {alu_op, alu_src_b, mem_bus.beat_idx, mem_bus.second_cycle}); end
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL reset_state got %0d want 0", state); end
        n_cmp++; if (trap_cause !== 2'b00) begin n_err++; $display("[TB] FAIL reset_cause got %b want 00", trap_cause); end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [2:0]  exp_st [4]  = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic [11:0] exp_ctl [4] = '{C_PCW, C_RR, 12'h000, C_RW};
        logic [5:0]  ops [6]     = '{6'd1, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5};
        logic [2:0]  exp_alu [6] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b101, 3'b001};
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk); opcode = ops[i]; mem_bus.mem_ready = 1'b1; #1;
                n_cmp++; if (state !== exp_st[c]) begin n_err++;
                    $display("[TB] FAIL alu_state op=%0d c=%0d got %0d want %0d", ops[i], c, state, exp_st[c]); end
                n_cmp++; if (ctl !== exp_ctl[c]) begin n_err++;
                    $display("[TB] FAIL alu_ctl op=%0d c=%0d got %h want %h", ops[i], c, ctl, exp_ctl[c]); end
                if (c == 2) begin
                    n_cmp++; if ({alu_op, alu_src_b} !== exp_alu[i]) begin n_err++;
                        $display("[TB] FAIL alu_sel op=%0d got %b want %b", ops[i], {alu_op, alu_src_b}, exp_alu[i]); end
                end
            end
            @(posedge clk); #1;
            n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL alu_done op=%0d got %0d want 0", ops[i], state); end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4]   = '{6'd10, 6'd10, 6'd11, 6'd12};
        logic [2:0] flags [4] = '{3'b100, 3'b011, 3'b010, 3'b110};
        logic       taken [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [11:0] exp_ctl;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk); opcode = ops[i]; {zero, positive, negative} = flags[i]; #1;
                exp_ctl = (c == 0) ? C_PCW : (c == 1) ? C_RR : (taken[i] ? (C_PCW | C_BR) : 12'h000);
                n_cmp++; if (ctl !== exp_ctl) begin n_err++;
                    $display("[TB] FAIL branch_ctl v=%0d c=%0d got %h want %h", i, c, ctl, exp_ctl); end
                if (c == 2) begin
                    n_cmp++; if ({state, alu_op, alu_src_b} !== {3'd2, 2'b01, 1'b0}) begin n_err++;
                        $display("[TB] FAIL branch_exec v=%0d got %b want 010010", i, {state, alu_op, alu_src_b}); end
                end
            end
            @(posedge clk); #1;
            n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL branch_done v=%0d got %0d want 0", i, state); end
        end
        {zero, positive, negative} = 3'b000;
    endtask

    task automatic test_jumps();
        logic [5:0]  ops [3]    = '{6'd13, 6'd14, 6'd15};
        logic [11:0] exec_c [3] = '{C_PCW | C_JR, C_PCW | C_JMP, C_PCW | C_JMP};
        int          len [3]    = '{3, 3, 4};
        logic [11:0] exp_ctl;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < len[i]; c++) begin
                @(negedge clk); opcode = ops[i]; #1;
                exp_ctl = (c == 0) ? C_PCW : (c == 1) ? C_RR : (c == 2) ? exec_c[i] : (C_RW | C_RWS);
                n_cmp++; if (ctl !== exp_ctl) begin n_err++;
                    $display("[TB] FAIL jump_ctl op=%0d c=%0d got %h want %h", ops[i], c, ctl, exp_ctl); end
            end
            @(posedge clk); #1;
            n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL jump_done op=%0d got %0d want 0", ops[i], state); end
        end
    endtask

    task automatic test_lw_wait();
        logic [2:0]  exp_st [8]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic [11:0] exp_ctl [8] = '{C_PCW, C_RR, 12'h000, C_MR | C_STALL, C_MR | C_STALL, C_MR | C_STALL,
                                     C_MR, C_RW | C_MTR};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); opcode = 6'd6; mem_bus.mem_ready = !(c >= 3 && c <= 5); #1;
            n_cmp++; if (state !== exp_st[c]) begin n_err++; $display("[TB] FAIL lw_state c=%0d got %0d want %0d", c, state, exp_st[c]); end
            n_cmp++; if (ctl !== exp_ctl[c]) begin n_err++; $display("[TB] FAIL lw_ctl c=%0d got %h want %h", c, ctl, exp_ctl[c]); end
            if (c == 2) begin
                n_cmp++; if ({alu_op, alu_src_b} !== 3'b001) begin n_err++;
                    $display("[TB] FAIL lw_addr got %b want 001", {alu_op, alu_src_b}); end
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL lw_done got %0d want 0", state); end
    endtask

    task automatic test_ldw();
        int          writes = 0;
        logic [2:0]  exp_st;
        logic [11:0] exp_ctl;
        logic [1:0]  exp_beat;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk); opcode = 6'd8; mem_bus.mem_ready = 1'b1; #1;
            exp_beat = (c < 3) ? 2'd0 : 2'((c - 3) / 2);
            exp_st   = (c < 3) ? 3'(c) : (((c - 3) % 2 == 1) ? 3'd4 : 3'd3);
            exp_ctl  = (c == 0) ? C_PCW : (c == 1) ? C_RR : (c == 2) ? 12'h000 :
                       (exp_st == 3'd4) ? (C_RW | C_MTR) : C_MR;
            if (reg_write) writes++;
            n_cmp++; if (state !== exp_st) begin n_err++; $display("[TB] FAIL ldw_state c=%0d got %0d want %0d", c, state, exp_st); end
            n_cmp++; if (ctl !== exp_ctl) begin n_err++; $display("[TB] FAIL ldw_ctl c=%0d got %h want %h", c, ctl, exp_ctl); end
            n_cmp++; if ({mem_bus.beat_idx, mem_bus.second_cycle} !== {exp_beat, exp_beat != 2'd0}) begin n_err++;
                $display("[TB] FAIL ldw_beat c=%0d got %b want %b", c, {mem_bus.beat_idx, mem_bus.second_cycle}, {exp_beat, exp_beat != 2'd0}); end
        end
        @(posedge clk); #1;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL ldw_done got %0d want 0", state); end
        n_cmp++; if (writes !== 4) begin n_err++; $display("[TB] FAIL ldw_writes got %0d want 4", writes); end
    endtask

    task automatic test_sdw();
        logic [11:0] exp_ctl;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); opcode = 6'd9; mem_bus.mem_ready = 1'b1; #1;
            exp_ctl = (c == 0) ? C_PCW : (c == 1) ? C_RR : (c == 2) ? 12'h000 : C_MW;
            n_cmp++; if (ctl !== exp_ctl) begin n_err++; $display("[TB] FAIL sdw_ctl c=%0d got %h want %h", c, ctl, exp_ctl); end
            if (c >= 3) begin
                n_cmp++; if ({state, mem_bus.beat_idx} !== {3'd3, 2'(c - 3)}) begin n_err++;
                    $display("[TB] FAIL sdw_beat c=%0d got %b want %b", c, {state, mem_bus.beat_idx}, {3'd3, 2'(c - 3)}); end
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL sdw_done got %0d want 0", state); end
    endtask

    task automatic test_traps();
        logic [5:0]  ops [2]   = '{6'd9, 6'd16};
        logic        exc [2]   = '{1'b1, 1'b0};
        logic [1:0]  cause [2] = '{2'b01, 2'b10};
        logic [11:0] exp_ctl;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk); opcode = ops[i]; exception = exc[i]; mem_bus.mem_ready = 1'b1; #1;
                exp_ctl = (c == 0) ? C_PCW : (c == 1) ? C_RR : (C_PCW | C_JMP | C_TRAP);
                n_cmp++; if (ctl !== exp_ctl) begin n_err++;
                    $display("[TB] FAIL trap_ctl op=%0d c=%0d got %h want %h", ops[i], c, ctl, exp_ctl); end
                if (c == 2) begin
                    n_cmp++; if ({state, trap_cause} !== {3'd5, cause[i]}) begin n_err++;
                        $display("[TB] FAIL trap_cause op=%0d got %b want %b", ops[i], {state, trap_cause}, {3'd5, cause[i]}); end
                end
            end
            @(posedge clk); #1;
            n_cmp++; if ({state, trap_cause} !== {3'd0, cause[i]}) begin n_err++;
                $display("[TB] FAIL trap_done op=%0d got %b want %b", ops[i], {state, trap_cause}, {3'd0, cause[i]}); end
        end
        exception = 1'b0;
    endtask

    task automatic test_timeout();
        logic [11:0] exp_ctl;
        // Stuck handshake: fifteen MEM cycles, then a bus-timeout trap.
        for (int c = 0; c < 19; c++) begin
            @(negedge clk); opcode = 6'd7; mem_bus.mem_ready = 1'b0; #1;
            exp_ctl = (c == 0) ? C_PCW : (c == 1) ? C_RR : (c == 2) ? 12'h000 :
                      (c < 18) ? (C_MW | C_STALL) : (C_PCW | C_JMP | C_TRAP);
            n_cmp++; if (ctl !== exp_ctl) begin n_err++; $display("[TB] FAIL tmo_ctl c=%0d got %h want %h", c, ctl, exp_ctl); end
            if (c == 18) begin
                n_cmp++; if ({state, trap_cause} !== {3'd5, 2'b11}) begin n_err++;
                    $display("[TB] FAIL tmo_cause got %b want 10111", {state, trap_cause}); end
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL tmo_done got %0d want 0", state); end
        // Ready on the last permitted cycle completes the store instead of trapping.
        for (int c = 0; c < 18; c++) begin
            @(negedge clk); opcode = 6'd7; mem_bus.mem_ready = (c == 17); #1;
            exp_ctl = (c == 0) ? C_PCW : (c == 1) ? C_RR : (c == 2) ? 12'h000 :
                      (c < 17) ? (C_MW | C_STALL) : C_MW;
            n_cmp++; if (ctl !== exp_ctl) begin n_err++; $display("[TB] FAIL edge_ctl c=%0d got %h want %h", c, ctl, exp_ctl); end
        end
        @(posedge clk); #1;
        n_cmp++; if ({state, trap_cause} !== {3'd0, 2'b11}) begin n_err++;
            $display("[TB] FAIL edge_done got %b want 00011", {state, trap_cause}); end
        // Reset in the middle of a wait drops the access at once.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); opcode = 6'd7; mem_bus.mem_ready = 1'b0;
        end
        #1;
        n_cmp++; if (ctl !== (C_MW | C_STALL)) begin n_err++; $display("[TB] FAIL rst_pre got %h want 081", ctl); end
        @(negedge clk); reset = 1'b1; #1;
        n_cmp++; if (ctl !== 12'h000) begin n_err++; $display("[TB] FAIL rst_abort got %h want 000", ctl); end
        @(negedge clk); #1;
        n_cmp++; if ({ctl, state, trap_cause, mem_bus.beat_idx} !== 19'd0) begin n_err++;
            $display("[TB] FAIL rst_after got %h want 0", {ctl, state, trap_cause, mem_bus.beat_idx}); end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    initial begin
        $display("[TB] mc_ctrl_unit directed run");
        test_reset();
        test_alu();
        test_branch();
        test_jumps();
        test_lw_wait();
        test_ldw();
        test_sdw();
        test_traps();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
